// File: rtl/wm8731_pkg.sv
// Shared state encoding and default constants for the WM8731 DAC transmitter.
package wm8731_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } tx_state_t;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_SLOT_BITS  = 32;
  localparam int unsigned DEF_BCLK_DIV   = 4;

endpackage

// File: rtl/wm8731_bclk_gen.sv
// BCLK divider; flags the Clk cycle in which BCLK has just gone (or starts) low.
module wm8731_bclk_gen
  import wm8731_pkg::*;
#(
  parameter int unsigned BCLK_DIV = DEF_BCLK_DIV
) (
  input  logic Clk,
  input  logic Reset_in,
  input  logic Run_in,
  output logic BClk_out,
  output logic FallEvent_out
);

  localparam int unsigned DVW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DVW-1:0] DIV_LAST = DVW'(BCLK_DIV - 1);

  logic [DVW-1:0] div_q;
  logic           bclk_q;

  always_ff @(posedge Clk or posedge Reset_in) begin
    if (Reset_in) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else if (!Run_in) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_q  <= '0;
      bclk_q <= ~bclk_q;
    end else begin
      div_q <= div_q + DVW'(1);
    end
  end

  // The first running cycle (counter and BCLK both at rest) also counts as a falling edge.
  assign FallEvent_out = Run_in && (div_q == '0) && !bclk_q;
  assign BClk_out      = bclk_q;

endmodule

// File: rtl/wm8731_dac_tx.sv
// I2S master transmitter for the WM8731 DAC: pops one show-ahead FIFO word per slot.
module wm8731_dac_tx
  import wm8731_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned SLOT_BITS  = DEF_SLOT_BITS,
  parameter int unsigned BCLK_DIV   = DEF_BCLK_DIV
) (
  input  logic                  Clk,
  input  logic                  Reset_in,
  input  logic                  Enable_in,
  input  logic [DATA_WIDTH-1:0] Data_in,
  input  logic                  Empty_in,
  output logic                  ReadEn_out,
  output logic                  BClk_out,
  output logic                  DacLrc_out,
  output logic                  DacDat_out,
  output logic                  Underrun_out,
  output logic                  Busy_out
);

  localparam int unsigned CW = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
  localparam logic [CW-1:0] LAST_BIT  = CW'(SLOT_BITS - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH);

  tx_state_t             state_q, state_next;
  logic [CW-1:0]         bitcnt_q;
  logic                  slot_q;
  logic [DATA_WIDTH-1:0] sreg_q;
  logic                  lrc_q, dat_q;
  logic                  fall_ev, slot_start, frame_end;
  logic                  read_en, underrun;

  wm8731_bclk_gen #(
    .BCLK_DIV(BCLK_DIV)
  ) u_bclk_gen (
    .Clk          (Clk),
    .Reset_in     (Reset_in),
    .Run_in       (state_q != ST_IDLE),
    .BClk_out     (BClk_out),
    .FallEvent_out(fall_ev)
  );

  always_comb begin
    state_next = state_q;
    read_en    = 1'b0;
    underrun   = 1'b0;
    slot_start = fall_ev && (bitcnt_q == '0);
    frame_end  = slot_start && !slot_q && (state_q == ST_STOP) && !Enable_in;
    case (state_q)
      ST_IDLE: if (Enable_in) state_next = ST_RUN;
      ST_RUN:  if (!Enable_in) state_next = ST_STOP;
      ST_STOP: begin
        if (Enable_in)      state_next = ST_RUN;
        else if (frame_end) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (slot_start && !frame_end) begin
      if (!Empty_in) read_en  = 1'b1;
      else           underrun = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset_in) begin
    if (Reset_in) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
      slot_q   <= 1'b0;
      sreg_q   <= '0;
      lrc_q    <= 1'b0;
      dat_q    <= 1'b0;
    end else begin
      state_q <= state_next;
      if (state_q == ST_IDLE) begin
        bitcnt_q <= '0;
        slot_q   <= 1'b0;
        lrc_q    <= 1'b0;
        dat_q    <= 1'b0;
      end else if (fall_ev) begin
        lrc_q <= slot_q;
        if (bitcnt_q == '0) begin
          dat_q  <= 1'b0;
          sreg_q <= read_en ? Data_in : '0;
        end else begin
          dat_q  <= (bitcnt_q <= DATA_LAST) ? sreg_q[DATA_WIDTH-1] : 1'b0;
          sreg_q <= {sreg_q[DATA_WIDTH-2:0], 1'b0};
        end
        if (bitcnt_q == LAST_BIT) begin
          bitcnt_q <= '0;
          slot_q   <= ~slot_q;
        end else begin
          bitcnt_q <= bitcnt_q + CW'(1);
        end
      end
    end
  end

  assign ReadEn_out   = read_en;
  assign Underrun_out = underrun;
  assign DacLrc_out   = lrc_q;
  assign DacDat_out   = dat_q;
  assign Busy_out     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wm8731_dac_tx.sv
// Self-checking bench: FIFO model, codec-side capture at BCLK rises, I2S slot model.
module tb_wm8731_dac_tx;

  localparam int DW  = 16;
  localparam int SB  = 32;
  localparam int DIV = 2;

  logic          Clk = 1'b0;
  logic          Reset_in, Enable_in, Empty_in;
  logic [DW-1:0] Data_in;
  logic          ReadEn_out, BClk_out, DacLrc_out, DacDat_out, Underrun_out, Busy_out;

  always #5 Clk = ~Clk;

  wm8731_dac_tx #(
    .DATA_WIDTH(DW),
    .SLOT_BITS (SB),
    .BCLK_DIV  (DIV)
  ) dut (
    .Clk         (Clk),
    .Reset_in    (Reset_in),
    .Enable_in   (Enable_in),
    .Data_in     (Data_in),
    .Empty_in    (Empty_in),
    .ReadEn_out  (ReadEn_out),
    .BClk_out    (BClk_out),
    .DacLrc_out  (DacLrc_out),
    .DacDat_out  (DacDat_out),
    .Underrun_out(Underrun_out),
    .Busy_out    (Busy_out)
  );

  logic [DW-1:0] fifo[$];
  int            pop_cyc[$];
  int            und_cyc[$];
  logic [1:0]    rise_q[$];
  int            cyc, dat_ones, bad_rd;
  logic          prev_bclk, rd;
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] slot_words[8];

  // FIFO model and bus monitor: refresh at negedge, sample at negedge+1, pop after posedge.
  initial begin
    Data_in   = '0;
    Empty_in  = 1'b1;
    cyc       = 0;
    dat_ones  = 0;
    bad_rd    = 0;
    prev_bclk = 1'b0;
    forever begin
      @(negedge Clk);
      Empty_in = (fifo.size() == 0);
      Data_in  = (fifo.size() != 0) ? fifo[0] : '0;
      #1;
      cyc++;
      rd = (ReadEn_out === 1'b1);
      if (rd) pop_cyc.push_back(cyc);
      if (rd && Empty_in) bad_rd++;
      if (Underrun_out === 1'b1) und_cyc.push_back(cyc);
      if (DacDat_out !== 1'b0) dat_ones++;
      if (BClk_out === 1'b1 && prev_bclk === 1'b0) rise_q.push_back({DacLrc_out, DacDat_out});
      prev_bclk = BClk_out;
      @(posedge Clk);
      #1;
      if (rd && fifo.size() != 0) void'(fifo.pop_front());
      Empty_in = (fifo.size() == 0);
      Data_in  = (fifo.size() != 0) ? fifo[0] : '0;
    end
  end

  // Codec view of rise k of a frame: slot k/SB, bit k%SB; MSB on bit 1, zeros elsewhere.
  function automatic logic [1:0] exp_rise(int k);
    int            s, n;
    logic [DW-1:0] w;
    logic          d;
    s = k / SB;
    n = k % SB;
    w = slot_words[s];
    d = (n >= 1 && n <= DW) ? w[DW-n] : 1'b0;
    return {((s % 2) == 1), d};
  endfunction

  task automatic go(input int drop_at, input int total);
    Enable_in = 1'b1;
    for (int i = 0; i <= total; i++) begin
      @(negedge Clk);
      if (i == drop_at) Enable_in = 1'b0;
    end
    #2;
  endtask

  task automatic idle_wait(input int n);
    repeat (n) @(negedge Clk);
    #2;
  endtask

  task automatic test_reset;
    Reset_in  = 1'b1;
    Enable_in = 1'b0;
    idle_wait(3);
    checks++;
    if ({BClk_out, DacLrc_out, DacDat_out, ReadEn_out, Underrun_out, Busy_out} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 000000",
               {BClk_out, DacLrc_out, DacDat_out, ReadEn_out, Underrun_out, Busy_out});
    end
    Reset_in = 1'b0;
    idle_wait(6);
    checks++;
    if ({BClk_out, DacLrc_out, DacDat_out, ReadEn_out, Underrun_out, Busy_out} !== 6'b0) begin
      errors++;
      $display("FAIL idle_no_enable got %b want 000000",
               {BClk_out, DacLrc_out, DacDat_out, ReadEn_out, Underrun_out, Busy_out});
    end
  endtask

  task automatic test_basic;
    int pb, rb, ub, bad, first;
    fifo.push_back(16'hA5C3);
    fifo.push_back(16'h0F0F);
    idle_wait(3);
    pb = pop_cyc.size(); rb = rise_q.size(); ub = und_cyc.size();
    slot_words[0] = 16'hA5C3; slot_words[1] = 16'h0F0F;
    go(200, 270);
    checks++;
    if (pop_cyc.size() - pb != 2) begin
      errors++; $display("FAIL basic_pops got %0d want 2", pop_cyc.size() - pb);
    end else begin
      checks++;
      if (pop_cyc[pb+1] - pop_cyc[pb] != 128) begin
        errors++; $display("FAIL basic_pop_gap got %0d want 128", pop_cyc[pb+1] - pop_cyc[pb]);
      end
    end
    checks++;
    if (rise_q.size() - rb != 2 * SB) begin
      errors++; $display("FAIL basic_rises got %0d want %0d", rise_q.size() - rb, 2 * SB);
    end
    bad = 0; first = -1;
    for (int k = 0; k < 2 * SB && rb + k < rise_q.size(); k++)
      if (rise_q[rb+k] !== exp_rise(k)) begin bad++; if (first < 0) first = k; end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL basic_serial_bits bad %0d first rise %0d got %b want %b",
               bad, first, rise_q[rb+first], exp_rise(first));
    end
    checks++;
    if (und_cyc.size() != ub || Busy_out !== 1'b0) begin
      errors++; $display("FAIL basic_end underruns %0d busy %b want 0 0", und_cyc.size() - ub, Busy_out);
    end
  endtask

  task automatic test_stop;
    int pb, rb, bad, first;
    for (int i = 0; i < 2; i++) begin
      slot_words[i] = DW'($urandom);
      fifo.push_back(slot_words[i]);
    end
    idle_wait(3);
    pb = pop_cyc.size(); rb = rise_q.size();
    go(40, 258);
    checks++;
    if ({BClk_out, DacLrc_out, DacDat_out, ReadEn_out, Underrun_out, Busy_out} !== 6'b0) begin
      errors++;
      $display("FAIL stop_idle_outputs got %b want 000000",
               {BClk_out, DacLrc_out, DacDat_out, ReadEn_out, Underrun_out, Busy_out});
    end
    checks++;
    if (pop_cyc.size() - pb != 2) begin
      errors++; $display("FAIL stop_pops got %0d want 2", pop_cyc.size() - pb);
    end
    bad = 0; first = -1;
    for (int k = 0; k < 2 * SB && rb + k < rise_q.size(); k++)
      if (rise_q[rb+k] !== exp_rise(k)) begin bad++; if (first < 0) first = k; end
    checks++;
    if (bad != 0 || rise_q.size() - rb != 2 * SB) begin
      errors++;
      $display("FAIL stop_serial_bits bad %0d rises %0d want 0 and %0d", bad, rise_q.size() - rb, 2 * SB);
    end
  endtask

  task automatic test_underrun;
    int pb, ub, db, gap_bad;
    idle_wait(2);
    pb = pop_cyc.size(); ub = und_cyc.size(); db = dat_ones;
    go(400, 520);
    checks++;
    if (pop_cyc.size() != pb) begin
      errors++; $display("FAIL underrun_pops got %0d want 0", pop_cyc.size() - pb);
    end
    checks++;
    if (dat_ones != db) begin
      errors++; $display("FAIL underrun_data_ones got %0d want 0", dat_ones - db);
    end
    checks++;
    if (und_cyc.size() - ub != 4) begin
      errors++; $display("FAIL underrun_count got %0d want 4", und_cyc.size() - ub);
    end
    gap_bad = 0;
    for (int i = ub + 1; i < und_cyc.size(); i++)
      if (und_cyc[i] - und_cyc[i-1] != 128) gap_bad++;
    checks++;
    if (gap_bad != 0) begin
      errors++; $display("FAIL underrun_spacing got %0d bad gaps want 0", gap_bad);
    end
    checks++;
    if (Busy_out !== 1'b0) begin
      errors++; $display("FAIL underrun_end_busy got %b want 0", Busy_out);
    end
  endtask

  task automatic test_reset_mid;
    logic [DW-1:0] w[4];
    int            pb, rb, bad, first;
    for (int i = 0; i < 4; i++) w[i] = DW'($urandom);
    for (int i = 0; i < 3; i++) fifo.push_back(w[i]);
    idle_wait(3);
    pb = pop_cyc.size();
    go(-1, 160);
    Reset_in  = 1'b1;
    Enable_in = 1'b0;
    #1;
    checks++;
    if ({BClk_out, DacLrc_out, DacDat_out, ReadEn_out, Underrun_out, Busy_out} !== 6'b0) begin
      errors++;
      $display("FAIL midreset_outputs got %b want 000000",
               {BClk_out, DacLrc_out, DacDat_out, ReadEn_out, Underrun_out, Busy_out});
    end
    idle_wait(3);
    Reset_in = 1'b0;
    idle_wait(20);
    checks++;
    if (pop_cyc.size() - pb != 2 || Busy_out !== 1'b0 || BClk_out !== 1'b0) begin
      errors++;
      $display("FAIL midreset_quiet pops %0d busy %b bclk %b want 2 0 0",
               pop_cyc.size() - pb, Busy_out, BClk_out);
    end
    fifo.push_back(w[3]);
    idle_wait(3);
    pb = pop_cyc.size(); rb = rise_q.size();
    slot_words[0] = w[2]; slot_words[1] = w[3];
    go(10, 270);
    checks++;
    if (rb >= rise_q.size() || rise_q[rb][1] !== 1'b0) begin
      errors++; $display("FAIL restart_first_lrc got %b want 0", (rb < rise_q.size()) ? rise_q[rb][1] : 1'bx);
    end
    bad = 0; first = -1;
    for (int k = 0; k < 2 * SB && rb + k < rise_q.size(); k++)
      if (rise_q[rb+k] !== exp_rise(k)) begin bad++; if (first < 0) first = k; end
    checks++;
    if (bad != 0 || rise_q.size() - rb != 2 * SB || pop_cyc.size() - pb != 2) begin
      errors++;
      $display("FAIL restart_frame bad %0d rises %0d pops %0d want 0 %0d 2",
               bad, rise_q.size() - rb, pop_cyc.size() - pb, 2 * SB);
    end
  endtask

  task automatic test_back_to_back;
    int pb, rb, ub, bad, first;
    for (int i = 0; i < 3; i++) begin
      slot_words[i] = DW'($urandom) | 16'h8001;
      fifo.push_back(slot_words[i]);
    end
    slot_words[3] = '0;
    idle_wait(3);
    pb = pop_cyc.size(); rb = rise_q.size(); ub = und_cyc.size();
    go(300, 520);
    checks++;
    if (pop_cyc.size() - pb != 3) begin
      errors++; $display("FAIL b2b_pops got %0d want 3", pop_cyc.size() - pb);
    end
    checks++;
    if (und_cyc.size() - ub != 1) begin
      errors++; $display("FAIL b2b_underruns got %0d want 1", und_cyc.size() - ub);
    end else if (pop_cyc.size() > pb) begin
      checks++;
      if (und_cyc[ub] - pop_cyc[pb] != 384) begin
        errors++; $display("FAIL b2b_underrun_slot got offset %0d want 384", und_cyc[ub] - pop_cyc[pb]);
      end
    end
    bad = 0; first = -1;
    for (int k = 0; k < 4 * SB && rb + k < rise_q.size(); k++)
      if (rise_q[rb+k] !== exp_rise(k)) begin bad++; if (first < 0) first = k; end
    checks++;
    if (bad != 0 || rise_q.size() - rb != 4 * SB) begin
      errors++;
      $display("FAIL b2b_serial_bits bad %0d first %0d rises %0d want 0 and %0d",
               bad, first, rise_q.size() - rb, 4 * SB);
    end
    checks++;
    if (bad_rd != 0) begin
      errors++; $display("FAIL read_while_empty got %0d want 0", bad_rd);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stop();
    test_underrun();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
